// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer (clk, reset, Addr word address, WE, Din in; Dout read data, IRQ out)
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, count_nxt;
  logic        irq_flag, flag_set, flag_clr, en_clr;
  logic        hit, wr_ctrl, wr_preset;
  logic [1:0]  off;
  assign hit       = Addr[29:2] == BASE_ADDR[31:4];
  assign off       = Addr[1:0];
  assign wr_ctrl   = WE && hit && off == 2'd0;
  assign wr_preset = WE && hit && off == 2'd1;
  assign Dout = !hit ? 32'd0 : off == 2'd0 ? {28'd0, ctrl} : off == 2'd1 ? preset : off == 2'd2 ? count : 32'd0;
  assign IRQ  = ctrl[3] & irq_flag;
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      IDLE: state_nxt = ctrl[0] ? LOAD : IDLE;
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl[0]) state_nxt = IDLE;
        else if (count > 32'd1) count_nxt = count - 32'd1;
        else begin
          count_nxt = 32'd0;
          flag_set  = 1'b1;
          state_nxt = INT;
        end
      end
      default: begin
        flag_clr  = ctrl[2:1] == 2'b01;
        en_clr    = ctrl[2:1] != 2'b01;
        state_nxt = ctrl[2:1] == 2'b01 ? LOAD : IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      ctrl     <= wr_ctrl ? Din[3:0] : {ctrl[3:1], ctrl[0] & ~en_clr};
      preset   <= wr_preset ? Din : preset;
      irq_flag <= (wr_ctrl || wr_preset || flag_clr) ? 1'b0 : flag_set ? 1'b1 : irq_flag;
    end
  end
endmodule
